// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: decode-stage sequencer for the immediate generator.
// Classifies each fetched opcode, drives imm_gen with the resulting format code
// and registers instruction, PC, immediate and classification toward execute
// behind valid/ready handshakes on both sides.
// Optional feature macro IMM_DECODE_SKID_EN: adds a second (skid) entry so that
// in_ready is registered and has no combinational path from out_ready.

package imm_decode_pkg;
    typedef enum logic [2:0] {
        IMM_I    = 3'd0,
        IMM_S    = 3'd1,
        IMM_B    = 3'd2,
        IMM_U    = 3'd3,
        IMM_J    = 3'd4,
        IMM_CSR  = 3'd5,
        IMM_NONE = 3'd7
    } imm_type_e;
endpackage

module imm_gen
    import imm_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      imm_type,
    output logic [XLEN-1:0] imm
);
    logic [31:0] imm32;

    // Assemble the RV32I immediate for the requested format.
    always_comb begin
        // NOTE: assigning a default first means every path drives imm32, so no latch is inferred.
        imm32 = '0;
        case (imm_type)
            IMM_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm32 = {instr[31:12], 12'd0};
            IMM_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            IMM_CSR: imm32 = {27'd0, instr[19:15]};
            default: imm32 = '0;
        endcase
    end

    // Widen to the datapath; zimm already has a zero top bit so sign-extension is safe.
    assign imm = XLEN'($signed(imm32));
endmodule

module imm_decode_ctrl
    import imm_decode_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_PC_TAG = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic            out_has_imm,
    output logic            out_illegal
);
    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        imm_type_e       imm_type;
        logic            has_imm;
        logic            illegal;
    } entry_t;

    localparam entry_t RESET_ENTRY = '{
        instr: '0, pc: RESET_PC_TAG, imm: '0, imm_type: IMM_NONE, has_imm: 1'b0, illegal: 1'b0
    };

`ifdef IMM_DECODE_SKID_EN
    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_FULL = 2'd1, ST_SKID = 2'd2} state_e;
    entry_t skid_q;
    logic   load_skid;
    logic   promote;
`else
    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_e;
`endif

    state_e          state_q, state_d;
    entry_t          main_q, in_entry;
    imm_type_e       dec_type;
    logic            dec_illegal;
    logic [XLEN-1:0] dec_imm;
    logic            in_xfer, out_xfer, load_main;

    // Classify the incoming opcode into an immediate format.
    always_comb begin
        dec_type    = IMM_NONE;
        dec_illegal = 1'b0;
        case (in_instr[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: dec_type = IMM_I;
            7'b0100011:                         dec_type = IMM_S;
            7'b1100011:                         dec_type = IMM_B;
            7'b0110111, 7'b0010111:             dec_type = IMM_U;
            7'b1101111:                         dec_type = IMM_J;
            7'b1110011: begin
                if (in_instr[14]) dec_type = IMM_CSR;
                else              dec_type = IMM_I;
            end
            7'b0110011:                         dec_type = IMM_NONE;
            default:                            dec_illegal = 1'b1;
        endcase
    end

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (in_instr),
        .imm_type (dec_type),
        .imm      (dec_imm)
    );

    assign in_entry = '{
        instr: in_instr, pc: in_pc, imm: dec_imm, imm_type: dec_type,
        has_imm: (dec_type != IMM_NONE), illegal: dec_illegal
    };

    assign out_valid = (state_q != ST_EMPTY);
`ifdef IMM_DECODE_SKID_EN
    // Only the registered state feeds in_ready, so out_ready never reaches fetch combinationally.
    assign in_ready  = (state_q != ST_SKID);
`else
    assign in_ready  = !out_valid || out_ready;
`endif
    // An input offered during flush is dropped, whatever in_ready says.
    assign in_xfer   = in_valid && in_ready && !flush;
    assign out_xfer  = out_valid && out_ready;

    // State register; reset discards any held entry immediately.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignment so all registers update together.
        if (rst) state_q <= ST_EMPTY;
        else     state_q <= state_d;
    end

    // Next-state and entry-movement decisions; flush overrides every transfer.
    always_comb begin
        state_d   = state_q;
        load_main = 1'b0;
`ifdef IMM_DECODE_SKID_EN
        load_skid = 1'b0;
        promote   = 1'b0;
`endif
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        load_main = 1'b1;
                        state_d   = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (in_xfer && out_xfer) begin
                        load_main = 1'b1;
`ifdef IMM_DECODE_SKID_EN
                    end else if (in_xfer) begin
                        load_skid = 1'b1;
                        state_d   = ST_SKID;
`endif
                    end else if (out_xfer) begin
                        state_d = ST_EMPTY;
                    end
                end
`ifdef IMM_DECODE_SKID_EN
                ST_SKID: begin
                    if (out_xfer) begin
                        promote = 1'b1;
                        state_d = ST_FULL;
                    end
                end
`endif
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // Output entry: loaded from decode, or from the skid slot when it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            main_q <= RESET_ENTRY;
        else if (load_main) main_q <= in_entry;
`ifdef IMM_DECODE_SKID_EN
        else if (promote)   main_q <= skid_q;
`endif
    end

`ifdef IMM_DECODE_SKID_EN
    // Skid slot captures the entry that arrived while execute was stalled.
    always_ff @(posedge clk) begin
        // NOTE: no reset on skid data; it is only read once the state says the slot is valid.
        if (load_skid) skid_q <= in_entry;
    end
`endif

    assign out_instr    = main_q.instr;
    assign out_pc       = out_valid ? main_q.pc : RESET_PC_TAG;
    assign out_imm      = main_q.imm;
    assign out_imm_type = main_q.imm_type;
    assign out_has_imm  = out_valid && main_q.has_imm;
    assign out_illegal  = out_valid && main_q.illegal;

    // Fetch must hold a stalled instruction steady until it is taken or flushed.
    assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready && !flush) |=> (in_valid && $stable(in_instr) && $stable(in_pc)));
endmodule

// File: doc/imm_decode_ctrl.md
Name: imm_decode_ctrl

Overview:
- Decode-stage sequencer for the immediate generator.
- Accepts fetched instructions over a valid/ready handshake and classifies each opcode into an imm_type code.
- Drives an internal imm_gen instance with that code, then registers instruction, PC, immediate and classification toward execute over a second valid/ready handshake.
- Supports flush (branch redirect) and backpressure. Sits between the fetch stage and the ID/EX boundary.

Parameters:
- XLEN, 32, width of PC and immediate datapath.
- RESET_PC_TAG, 0, value driven on out_pc while no entry is valid.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  block accepts the instruction this cycle.
- in_instr  in  32  raw instruction.
- in_pc  in  XLEN  PC of in_instr.
- flush  in  1  discard all held and incoming entries.
- out_valid  out  1  registered entry available to execute.
- out_ready  in  1  execute consumes the entry.
- out_instr  out  32  held instruction.
- out_pc  out  XLEN  held PC.
- out_imm  out  XLEN  generated immediate.
- out_imm_type  out  3  0 I, 1 S, 2 B, 3 U, 4 J, 5 CSR-zimm, 7 none.
- out_has_imm  out  1  instruction carries an immediate.
- out_illegal  out  1  opcode not recognised.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: out_valid=0, out_instr=0, out_pc=RESET_PC_TAG, out_imm=0, out_imm_type=7, out_has_imm=0, out_illegal=0, in_ready=1 after reset release.
- Opcode classification (instr[6:0]):
  - 0010011, 0000011, 1100111 -> I.
  - 0100011 -> S.
  - 1100011 -> B.
  - 0110111, 0010111 -> U.
  - 1101111 -> J.
  - 1110011 with funct3[2]=1 -> CSR (zimm = instr[19:15], zero-extended).
  - 1110011 with funct3[2]=0 -> I.
  - 0110011 -> type 7, has_imm=0, imm=0.
  - All other opcodes -> illegal=1, type 7, imm=0.
- Immediate values: follow RV32I encoding, sign-extended from the top immediate bit; U is instr[31:12]<<12. Immediate is computed combinationally from in_instr and captured in the same edge as the instruction.
- Transfers: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
- Latency: 1 cycle from input transfer to out_valid.
- State machine (base build): EMPTY, FULL.
  - in_ready = !out_valid | out_ready (combinational).
  - EMPTY + input transfer -> FULL.
  - FULL + output transfer without input transfer -> EMPTY.
  - FULL + simultaneous input and output transfer -> FULL, new entry loaded.
- Output stability: while out_valid=1 and out_ready=0, all out_* hold stable.
- Flush:
  - Next edge out_valid=0; state returns to EMPTY.
  - An input presented in the flush cycle is dropped and in_ready is ignored.
  - Flush has priority over every transfer.
- Invalid outputs: while out_valid=0, out_* data are don't-care except out_has_imm=0 and out_illegal=0.
- Reset mid-operation: the held entry is discarded immediately.
- Fetch protocol: in_valid may not drop, and in_instr/in_pc may not change, until the transfer occurs. Assertion only.

Optional Feature:
- IMM_DECODE_SKID_EN.
- When defined: a 2-entry skid buffer, states EMPTY, FULL, SKID.
  - in_ready is a registered signal = !skid_valid, with no combinational path from out_ready.
  - FULL + input transfer while out_ready=0 -> SKID; the extra entry is held in the skid register.
  - SKID + output transfer -> FULL; the skid entry is promoted.
  - Full throughput is maintained and order is preserved.
  - Flush clears both entries.
- When undefined: base EMPTY/FULL behaviour above.

Test Plan:
- LUI 0x12345037 sent, out_ready=1 -> next cycle out_valid=1, out_imm=0x12345000, type=3, has_imm=1.
- ADDI 0xFFF00093, then BEQ 0xFE000EE3 back-to-back -> imm 0xFFFFFFFF type 0, then 0xFFFFFFFC type 2, one per cycle.
- SW 0x0020A423 with out_ready=0 for 3 cycles -> out_imm=8, type 1, outputs stable.
  - Base build: in_ready=0.
  - Skid build: one more instruction accepted, then in_ready=0.
- CSRRWI 0x3400D073 -> out_imm=0x00000001, type 5. Instruction 0x0000007F -> out_illegal=1, type 7, imm 0.
- FULL (skid build: SKID) with flush=1 and in_valid=1 -> next cycle out_valid=0, the incoming instruction is never output.
- Reset asserted while FULL -> out_valid=0 immediately; in_ready=1 after release.
